// File: rtl/vote_link_ctrl.sv
// Voting-terminal link controller: collects a parity-protected vote word and exchanges
// words with a peer over a four-phase rts/rtr/cts/ctr handshake, with watchdog and self-test.
module vote_link_ctrl #(
    parameter int unsigned VOTE_W     = 2,
    parameter int unsigned END_CODE   = 6,
    parameter int unsigned MAX_ROUNDS = 8,
    parameter int unsigned TIMEOUT    = 1024,
    parameter int unsigned SIG        = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              test,
    input  logic              start,
    input  logic              key,
    input  logic [VOTE_W-1:0] button,
    input  logic              rts,
    input  logic              rtr,
    input  logic [VOTE_W+1:0] v_in,
    output logic [VOTE_W+1:0] v_out,
    output logic              cts,
    output logic              ctr,
    output logic              parity_err,
    output logic              timeout,
    output logic [7:0]        round_cnt
);

    localparam int unsigned W    = VOTE_W + 2;
    localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [W-1:0]    END_W   = W'(END_CODE);
    localparam logic [W-1:0]    SIG_W   = W'(SIG);
    localparam logic [7:0]      MAX_R8  = 8'(MAX_ROUNDS);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        STARTUP,
        STANDBY,
        GET_IN,
        START_TX,
        SEND,
        TX_2_RX,
        RECEIVE,
        RX_2_TX,
        END_TX,
        TEST_1,
        TEST_2
    } state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      word_q, word_d;
    logic [VOTE_W-1:0] last_q, last_d;
    logic [W-1:0]      v_out_q, v_out_d;
    logic              cts_q, cts_d;
    logic              ctr_q, ctr_d;
    logic              perr_q, perr_d;
    logic              timeout_q, timeout_d;
    logic [7:0]        round_q, round_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              watched;
    logic              hs_done;

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        last_d    = last_q;
        v_out_d   = v_out_q;
        cts_d     = cts_q;
        ctr_d     = ctr_q;
        perr_d    = perr_q;
        timeout_d = 1'b0;
        round_d   = round_q;
        wd_d      = '0;
        watched   = 1'b0;
        hs_done   = 1'b0;

        unique case (state_q)
            STARTUP: begin
                word_d  = '0;
                cts_d   = 1'b0;
                ctr_d   = 1'b0;
                state_d = test ? STANDBY : TEST_1;
            end
            STANDBY: begin
                cts_d = rtr;
                if (start) begin
                    word_d  = '0;
                    round_d = '0;
                    state_d = GET_IN;
                end
            end
            GET_IN: begin
                if (!start) begin
                    state_d = START_TX;
                end else if (key) begin
                    word_d[0] = 1'b1;
                    for (int unsigned i = 0; i < VOTE_W; i++) begin
                        if (button[i] && !last_q[i]) word_d[i+1] = ~word_q[i+1];
                    end
                    last_d = button;
                end else begin
                    word_d = '0;
                end
            end
            START_TX: begin
                word_d[W-1] = ^word_q[W-2:0];
                perr_d      = 1'b0;
                state_d     = SEND;
            end
            SEND: begin
                if (rtr) begin
                    v_out_d = word_q;
                    cts_d   = 1'b1;
                    state_d = (word_q == END_W || round_q == MAX_R8) ? END_TX : TX_2_RX;
                end
            end
            TX_2_RX: begin
                watched = 1'b1;
                hs_done = !rts;
                if (hs_done) begin
                    ctr_d   = 1'b1;
                    state_d = RECEIVE;
                end
            end
            RECEIVE: begin
                watched = 1'b1;
                hs_done = rts;
                if (hs_done) begin
                    ctr_d   = 1'b0;
                    state_d = RX_2_TX;
                    round_d = (round_q == 8'hFF) ? round_q : round_q + 8'd1;
                    // A corrupted word is dropped so the previous one goes out again.
                    if (^v_in == 1'b0) word_d = v_in;
                    else               perr_d = 1'b1;
                end
            end
            RX_2_TX: begin
                watched = 1'b1;
                hs_done = !rtr;
                if (hs_done) begin
                    cts_d   = 1'b0;
                    state_d = SEND;
                end
            end
            END_TX: begin
                watched = 1'b1;
                hs_done = !rtr;
                if (hs_done) begin
                    cts_d   = 1'b0;
                    state_d = STANDBY;
                end
            end
            TEST_1: begin
                word_d = v_in;
                if (&v_in) state_d = TEST_2;
            end
            TEST_2: begin
                word_d  = SIG_W;
                state_d = SEND;
            end
            default: state_d = STARTUP;
        endcase

        // Handshake completion on the terminal count beats the watchdog.
        if (watched && !hs_done && TIMEOUT != 0) begin
            if (wd_q == WD_LAST) begin
                timeout_d = 1'b1;
                cts_d     = 1'b0;
                ctr_d     = 1'b0;
                state_d   = STANDBY;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= STARTUP;
            word_q    <= '0;
            last_q    <= '0;
            v_out_q   <= '0;
            cts_q     <= 1'b0;
            ctr_q     <= 1'b0;
            perr_q    <= 1'b0;
            timeout_q <= 1'b0;
            round_q   <= '0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            last_q    <= last_d;
            v_out_q   <= v_out_d;
            cts_q     <= cts_d;
            ctr_q     <= ctr_d;
            perr_q    <= perr_d;
            timeout_q <= timeout_d;
            round_q   <= round_d;
            wd_q      <= wd_d;
        end
    end

    assign v_out      = v_out_q;
    assign cts        = cts_q;
    assign ctr        = ctr_q;
    assign parity_err = perr_q;
    assign timeout    = timeout_q;
    assign round_cnt  = round_q;

endmodule

// File: tb/tb_vote_link_ctrl.sv
// Directed bench for vote_link_ctrl: instance a uses default parameters,
// instance b uses TIMEOUT=16 and MAX_ROUNDS=2; both share stimulus.
module tb_vote_link_ctrl;

    logic       clk = 1'b0;
    logic       reset, test, start, key, rts, rtr;
    logic [1:0] button;
    logic [3:0] v_in;

    logic [3:0] a_vout, b_vout;
    logic       a_cts, a_ctr, a_perr, a_to;
    logic       b_cts, b_ctr, b_perr, b_to;
    logic [7:0] a_round, b_round;

    int n_checks = 0;
    int n_fail   = 0;
    int early;

    always #5 clk = ~clk;

    vote_link_ctrl #(.VOTE_W(2), .END_CODE(6), .MAX_ROUNDS(8), .TIMEOUT(1024), .SIG(9)) dut_a (
        .clock(clk), .reset(reset), .test(test), .start(start), .key(key),
        .button(button), .rts(rts), .rtr(rtr), .v_in(v_in),
        .v_out(a_vout), .cts(a_cts), .ctr(a_ctr), .parity_err(a_perr),
        .timeout(a_to), .round_cnt(a_round)
    );

    vote_link_ctrl #(.VOTE_W(2), .END_CODE(6), .MAX_ROUNDS(2), .TIMEOUT(16), .SIG(9)) dut_b (
        .clock(clk), .reset(reset), .test(test), .start(start), .key(key),
        .button(button), .rts(rts), .rtr(rtr), .v_in(v_in),
        .v_out(b_vout), .cts(b_cts), .ctr(b_ctr), .parity_err(b_perr),
        .timeout(b_to), .round_cnt(b_round)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1; test = 1; start = 0; key = 0; button = '0;
        rts = 1; rtr = 0; v_in = '0;
        tick(2);
        check_eq("rst_vout",  a_vout,  4'h0);
        check_eq("rst_cts",   a_cts,   1'b0);
        check_eq("rst_ctr",   a_ctr,   1'b0);
        check_eq("rst_perr",  a_perr,  1'b0);
        check_eq("rst_to",    a_to,    1'b0);
        check_eq("rst_round", a_round, 8'd0);

        // 1: vote b0 then b1 with key held; parity of 0111 gives 1111
        reset = 0; tick(1);
        start = 1; key = 1; tick(1);
        tick(1);
        button = 2'b01; tick(1); button = 2'b00; tick(1);
        button = 2'b10; tick(1); button = 2'b00; tick(1);
        start = 0; key = 0; tick(1);
        rtr = 1; tick(1);
        check_eq("t1_vout_pre", a_vout, 4'h0);
        tick(1);
        check_eq("t1_vout", a_vout, 4'b1111);
        check_eq("t1_cts",  a_cts,  1'b1);
        tick(3);
        check_eq("t1_wait_rts", a_ctr, 1'b0);

        // 2: one round trip, then peer returns END_CODE
        rts = 0; v_in = 4'b0101; tick(1);
        check_eq("t2_ctr_hi", a_ctr, 1'b1);
        rts = 1; tick(1);
        check_eq("t2_ctr_lo", a_ctr, 1'b0);
        check_eq("t2_round1", a_round, 8'd1);
        rtr = 0; tick(1);
        check_eq("t2_cts_lo", a_cts, 1'b0);
        rtr = 1; tick(1);
        check_eq("t2_vout5", a_vout, 4'b0101);
        check_eq("t2_cts_hi", a_cts, 1'b1);
        rts = 0; v_in = 4'b0110; tick(1);
        rts = 1; tick(1);
        check_eq("t2_round2", a_round, 8'd2);
        rtr = 0; tick(1);
        rtr = 1; tick(1);
        check_eq("t2_vout_end", a_vout, 4'b0110);
        tick(1);
        check_eq("t2_endtx_hold", a_cts, 1'b1);
        rtr = 0; tick(1);
        check_eq("t2_endtx_done", a_cts, 1'b0);
        rtr = 1; tick(1);
        check_eq("t2_standby_follow", a_cts, 1'b1);
        rtr = 0; tick(1);
        check_eq("t2_standby_follow0", a_cts, 1'b0);

        // 3: odd-parity receive is dropped and flagged
        start = 1; tick(1);
        check_eq("t3_round_clr", a_round, 8'd0);
        key = 1; button = 2'b01; tick(1);
        button = 2'b00; tick(1);
        start = 0; key = 0; tick(1);
        tick(1);
        rtr = 1; tick(1);
        check_eq("t3_vout3", a_vout, 4'b0011);
        rts = 0; v_in = 4'b0001; tick(1);
        rts = 1; tick(1);
        check_eq("t3_perr", a_perr, 1'b1);
        check_eq("t3_round", a_round, 8'd1);
        rtr = 0; tick(1);
        rtr = 1; tick(1);
        check_eq("t3_retx", a_vout, 4'b0011);
        rts = 0; v_in = 4'b0110; tick(1);
        rts = 1; tick(1);
        check_eq("t3_perr_sticky", a_perr, 1'b1);
        rtr = 0; tick(1);
        rtr = 1; tick(1);
        rtr = 0; tick(1);
        start = 1; tick(1);
        key = 1; tick(1);
        start = 0; key = 0; tick(1);
        check_eq("t3_perr_pre_clr", a_perr, 1'b1);
        tick(1);
        check_eq("t3_perr_clr", a_perr, 1'b0);
        rtr = 1; tick(1);
        check_eq("t3_vout_keyonly", a_vout, 4'b1001);

        // 5: self-test path loads SIG after all-ones
        reset = 1; test = 0; rtr = 0; rts = 1; v_in = '0; tick(2);
        reset = 0; tick(1);
        v_in = 4'b1011; tick(5);
        check_eq("t5_vout_idle", a_vout, 4'h0);
        v_in = 4'b1111; tick(1);
        v_in = 4'b0000; tick(1);
        rtr = 1; tick(1);
        check_eq("t5_sig", a_vout, 4'b1001);
        check_eq("t5_cts", a_cts, 1'b1);

        // 4: watchdog on instance b (TIMEOUT=16)
        reset = 1; test = 1; rtr = 1; rts = 1; v_in = '0; tick(2);
        reset = 0; tick(1);
        start = 1; tick(1);
        start = 0; tick(1);
        tick(1);
        tick(1);
        check_eq("t4_entry_cts", b_cts, 1'b1);
        early = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (b_to) early++;
        end
        check_eq("t4_no_early", early, 0);
        tick(1);
        check_eq("t4_to_pulse", b_to, 1'b1);
        check_eq("t4_to_cts", b_cts, 1'b0);
        check_eq("t4_to_ctr", b_ctr, 1'b0);
        tick(1);
        check_eq("t4_to_one_cycle", b_to, 1'b0);
        check_eq("t4_standby", b_cts, 1'b1);
        check_eq("t4_round_hold", b_round, 8'd0);

        start = 1; tick(1);
        start = 0; tick(1);
        tick(1);
        tick(1);
        early = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (b_to) early++;
        end
        check_eq("t4b_no_early", early, 0);
        rts = 0; v_in = 4'b0101; tick(1);
        check_eq("t4b_hs_wins_to", b_to, 1'b0);
        check_eq("t4b_hs_wins_ctr", b_ctr, 1'b1);
        rts = 1; tick(1);
        check_eq("t4b_round1", b_round, 8'd1);

        // 6: round limit (MAX_ROUNDS=2) and reset mid-RECEIVE
        rtr = 0; tick(1);
        rtr = 1; tick(1);
        check_eq("t6_vout5", b_vout, 4'b0101);
        rts = 0; v_in = 4'b0011; tick(1);
        rts = 1; tick(1);
        check_eq("t6_round2", b_round, 8'd2);
        rtr = 0; tick(1);
        rtr = 1; tick(1);
        check_eq("t6_vout3", b_vout, 4'b0011);
        check_eq("t6_cts", b_cts, 1'b1);
        rtr = 0; tick(1);
        check_eq("t6_end_tx", b_cts, 1'b0);
        rtr = 1; start = 1; tick(1);
        key = 1; tick(1);
        start = 0; key = 0; tick(1);
        tick(1);
        tick(1);
        check_eq("t6_vout9", b_vout, 4'b1001);
        rts = 0; tick(1);
        check_eq("t6_rx_ctr", b_ctr, 1'b1);
        reset = 1; tick(1);
        check_eq("t6_rst_vout", b_vout, 4'h0);
        check_eq("t6_rst_cts",  b_cts,  1'b0);
        check_eq("t6_rst_ctr",  b_ctr,  1'b0);
        check_eq("t6_rst_perr", b_perr, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
